// File: rtl/dist_seq_nn_if.sv
// Bus bundle between dist_seq_nn, its BRAM and the distance core.
// master: the sequencer side; slave: the environment side (BRAM, core, host).
interface dist_seq_nn_if #(
  parameter int VARWIDTH  = 32,
  parameter int VECWIDTH  = 10,
  parameter int MAXVECS   = 16,
  parameter int ADDRWIDTH = 8
);
  // host control
  logic                              STARTCALC;
  logic [$clog2(MAXVECS+1)-1:0]      NUM_OF_VECTORS;
  logic [ADDRWIDTH-1:0]              BASE_ADDR;
  // BRAM
  logic [ADDRWIDTH-1:0]              ADDR_Bram;
  logic [3:0]                        FLAG_Bram;
  logic [VARWIDTH-1:0]               DATA_Bram;
  // distance core
  logic [VARWIDTH*VECWIDTH-1:0]      invec0;
  logic [VARWIDTH*VECWIDTH-1:0]      invec1;
  logic                              EN_Pipe;
  logic                              EN_Acc;
  logic                              EN_Sqrt;
  logic                              RST_Acc;
  logic                              RST_Sqrt;
  logic                              RDY_Sqrt;
  logic [VARWIDTH-1:0]               DIST_In;
  // result
  logic [$clog2(MAXVECS)-1:0]        BEST_IDX;
  logic [VARWIDTH-1:0]               BEST_DIST;
  logic                              BUSY;
  logic                              DONE;
  logic                              ERR;

  modport master (
    input  STARTCALC, NUM_OF_VECTORS, BASE_ADDR, DATA_Bram, RDY_Sqrt, DIST_In,
    output ADDR_Bram, FLAG_Bram, invec0, invec1, EN_Pipe, EN_Acc, EN_Sqrt,
           RST_Acc, RST_Sqrt, BEST_IDX, BEST_DIST, BUSY, DONE, ERR
  );

  modport slave (
    output STARTCALC, NUM_OF_VECTORS, BASE_ADDR, DATA_Bram, RDY_Sqrt, DIST_In,
    input  ADDR_Bram, FLAG_Bram, invec0, invec1, EN_Pipe, EN_Acc, EN_Sqrt,
           RST_Acc, RST_Sqrt, BEST_IDX, BEST_DIST, BUSY, DONE, ERR
  );
endinterface

// File: rtl/dist_seq_nn.sv
// dist_seq_nn: nearest-neighbour sequencer between a 1-cycle-latency BRAM and
// the Euclidean distance core. Loads the query vector once, then for every
// candidate loads it, clears and runs the core, and keeps the running minimum.
//
// Optional build macro DIST_TIMEOUT_EN: adds a CALC watchdog that flags ERR and
// skips the candidate when the core never reports ready. Without it, CALC
// waits indefinitely and ERR stays 0.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for STARTCALC
// LDQ    | reading query elements into invec0 (+1 drain cycle)
// LDC    | reading candidate k elements into invec1 (+1 drain cycle)
// CLR    | one-cycle clear of the core accumulator and sqrt
// CALC   | core enabled, waiting for RDY_Sqrt
// CMP    | compare sampled distance against the running best
// FIN    | finishing; DONE is raised for the following cycle
module dist_seq_nn #(
  parameter int VARWIDTH  = 32,
  parameter int VECWIDTH  = 10,
  parameter int MAXVECS   = 16,
  parameter int ADDRWIDTH = 8,
  parameter int TIMEOUT   = 256
) (
  input  logic          clk,
  input  logic          RST,
  dist_seq_nn_if.master bus
);

  localparam int CW = $clog2(MAXVECS + 1);
  localparam int IW = $clog2(MAXVECS);
  localparam int EW = $clog2(VECWIDTH + 1);
  localparam int VW = VARWIDTH * VECWIDTH;

  localparam logic [ADDRWIDTH-1:0] VEC_STEP = ADDRWIDTH'(VECWIDTH);
  localparam logic [EW-1:0]        EL_LAST  = EW'(VECWIDTH - 1);
  localparam logic [EW-1:0]        EL_DRAIN = EW'(VECWIDTH);
  localparam logic [CW-1:0]        CNT_MAX  = CW'(MAXVECS);

`ifdef DIST_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDQ  = 3'd1,
    S_LDC  = 3'd2,
    S_CLR  = 3'd3,
    S_CALC = 3'd4,
    S_CMP  = 3'd5,
    S_FIN  = 3'd6
  } state_t;

  state_t                state_q,     state_d;
  logic [CW-1:0]         cnt_q,       cnt_d;
  logic [IW-1:0]         k_q,         k_d;
  logic [EW-1:0]         cyc_q,       cyc_d;
  logic [ADDRWIDTH-1:0]  addr_q,      addr_d;
  logic [ADDRWIDTH-1:0]  nxt_base_q,  nxt_base_d;
  logic                  cs_q,        cs_d;
  logic                  oe_q,        oe_d;
  logic                  ldq_q,       ldq_d;
  logic [VW-1:0]         invec0_q,    invec0_d;
  logic [VW-1:0]         invec1_q,    invec1_d;
  logic                  en_q,        en_d;
  logic                  rst_core_q,  rst_core_d;
  logic [VARWIDTH-1:0]   dist_q,      dist_d;
  logic [VARWIDTH-1:0]   best_dist_q, best_dist_d;
  logic [IW-1:0]         best_idx_q,  best_idx_d;
  logic                  busy_q,      busy_d;
  logic                  done_q,      done_d;
  logic                  err_q,       err_d;
`ifdef DIST_TIMEOUT_EN
  logic [TW-1:0]         tmr_q,       tmr_d;
`endif
  logic                  advance;

  // Next-state and next-output computation for the whole sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    cyc_d       = cyc_q;
    addr_d      = addr_q;
    nxt_base_d  = nxt_base_q;
    cs_d        = cs_q;
    oe_d        = oe_q;
    ldq_d       = ldq_q;
    invec0_d    = invec0_q;
    invec1_d    = invec1_q;
    en_d        = en_q;
    rst_core_d  = 1'b0;
    dist_d      = dist_q;
    best_dist_d = best_dist_q;
    best_idx_d  = best_idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
`ifdef DIST_TIMEOUT_EN
    tmr_d       = tmr_q;
`endif
    advance     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.STARTCALC) begin
          cnt_d       = (bus.NUM_OF_VECTORS > CNT_MAX) ? CNT_MAX : bus.NUM_OF_VECTORS;
          best_dist_d = '1;
          best_idx_d  = '0;
          err_d       = 1'b0;
          busy_d      = 1'b1;
          k_d         = '0;
          cyc_d       = '0;
          addr_d      = bus.BASE_ADDR;
          nxt_base_d  = bus.BASE_ADDR + VEC_STEP;
          if (bus.NUM_OF_VECTORS == '0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_LDQ;
            cs_d    = 1'b1;
            oe_d    = 1'b1;
            ldq_d   = 1'b1;
          end
        end
      end

      S_LDQ, S_LDC: begin
        // Data for the address issued last cycle is on DATA_Bram now.
        for (int e = 0; e < VECWIDTH; e++) begin
          if (cyc_q == EW'(e + 1)) begin
            if (state_q == S_LDQ) invec0_d[e*VARWIDTH +: VARWIDTH] = bus.DATA_Bram;
            else                  invec1_d[e*VARWIDTH +: VARWIDTH] = bus.DATA_Bram;
          end
        end
        if (cyc_q == EL_DRAIN) begin
          cyc_d = '0;
          if (state_q == S_LDQ) begin
            state_d    = S_LDC;
            ldq_d      = 1'b0;
            addr_d     = nxt_base_q;
            nxt_base_d = nxt_base_q + VEC_STEP;
            cs_d       = 1'b1;
            oe_d       = 1'b1;
          end else begin
            state_d    = S_CLR;
            rst_core_d = 1'b1;
          end
        end else begin
          cyc_d = cyc_q + EW'(1);
          if (cyc_q == EL_LAST) begin
            cs_d = 1'b0;
            oe_d = 1'b0;
          end else begin
            addr_d = addr_q + ADDRWIDTH'(1);
          end
        end
      end

      S_CLR: begin
        en_d    = 1'b1;
        state_d = S_CALC;
`ifdef DIST_TIMEOUT_EN
        tmr_d   = TMR_LOAD;
`endif
      end

      S_CALC: begin
        if (bus.RDY_Sqrt) begin
          dist_d  = bus.DIST_In;
          en_d    = 1'b0;
          state_d = S_CMP;
        end
`ifdef DIST_TIMEOUT_EN
        else if (tmr_q == '0) begin
          // Core never answered: flag it and move on without comparing.
          err_d   = 1'b1;
          en_d    = 1'b0;
          advance = 1'b1;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
`endif
      end

      S_CMP: begin
        // Strict compare keeps the earlier index on ties.
        if (dist_q < best_dist_q) begin
          best_dist_d = dist_q;
          best_idx_d  = k_q;
        end
        advance = 1'b1;
      end

      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (CW'(k_q) + CW'(1) >= cnt_q) begin
        state_d = S_FIN;
      end else begin
        k_d        = k_q + IW'(1);
        state_d    = S_LDC;
        cyc_d      = '0;
        addr_d     = nxt_base_q;
        nxt_base_d = nxt_base_q + VEC_STEP;
        cs_d       = 1'b1;
        oe_d       = 1'b1;
      end
    end
  end

  // State and output registers; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      k_q         <= '0;
      cyc_q       <= '0;
      addr_q      <= '0;
      nxt_base_q  <= '0;
      cs_q        <= 1'b0;
      oe_q        <= 1'b0;
      ldq_q       <= 1'b0;
      invec0_q    <= '0;
      invec1_q    <= '0;
      en_q        <= 1'b0;
      rst_core_q  <= 1'b0;
      dist_q      <= '0;
      best_dist_q <= '0;
      best_idx_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef DIST_TIMEOUT_EN
      tmr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      cyc_q       <= cyc_d;
      addr_q      <= addr_d;
      nxt_base_q  <= nxt_base_d;
      cs_q        <= cs_d;
      oe_q        <= oe_d;
      ldq_q       <= ldq_d;
      invec0_q    <= invec0_d;
      invec1_q    <= invec1_d;
      en_q        <= en_d;
      rst_core_q  <= rst_core_d;
      dist_q      <= dist_d;
      best_dist_q <= best_dist_d;
      best_idx_q  <= best_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef DIST_TIMEOUT_EN
      tmr_q       <= tmr_d;
`endif
    end
  end

  assign bus.ADDR_Bram = addr_q;
  assign bus.FLAG_Bram = {cs_q, 1'b0, oe_q, ldq_q};
  assign bus.invec0    = invec0_q;
  assign bus.invec1    = invec1_q;
  assign bus.EN_Pipe   = en_q;
  assign bus.EN_Acc    = en_q;
  assign bus.EN_Sqrt   = en_q;
  assign bus.RST_Acc   = rst_core_q;
  assign bus.RST_Sqrt  = rst_core_q;
  assign bus.BEST_IDX  = best_idx_q;
  assign bus.BEST_DIST = best_dist_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.ERR       = err_q;

endmodule

// File: tb/tb_dist_seq_nn.sv
// Bench for dist_seq_nn: BRAM model, stub distance core and a reference model
// of the expected nearest candidate, address stream and loaded vectors.
module tb_dist_seq_nn;
  localparam int VARW = 32;
  localparam int VECW = 4;
  localparam int MAXV = 16;
  localparam int AW   = 8;
  localparam int TMO  = 8;
  localparam int CW   = $clog2(MAXV + 1);
  localparam int VW   = VARW * VECW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dist_seq_nn_if #(.VARWIDTH(VARW), .VECWIDTH(VECW), .MAXVECS(MAXV), .ADDRWIDTH(AW)) bus ();

  dist_seq_nn #(.VARWIDTH(VARW), .VECWIDTH(VECW), .MAXVECS(MAXV),
                .ADDRWIDTH(AW), .TIMEOUT(TMO)) dut (.clk(clk), .RST(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // BRAM contents and 1-cycle read model.
  logic [VARW-1:0] mem [256];
  always @(posedge clk)
    if (bus.FLAG_Bram[3] && bus.FLAG_Bram[1]) bus.DATA_Bram <= mem[bus.ADDR_Bram];

  // Every cycle with cs high: record {query flag, address}; note any write.
  logic [AW:0] addr_log [$];
  int we_seen = 0;
  always @(posedge clk)
    if (!rst && bus.FLAG_Bram[3]) begin
      addr_log.push_back({bus.FLAG_Bram[0], bus.ADDR_Bram});
      if (bus.FLAG_Bram[2]) we_seen++;
    end

  // Stub distance core: random latency, one-cycle RDY, distance from a table.
  logic [VARW-1:0] dist_tab [MAXV];
  int              hang_cand = -1;
  logic [VW-1:0]   exp_q;
  logic [VW-1:0]   exp_c [MAXV];
  int              cand = 0;
  int              cur  = 0;
  int              lat  = 0;
  bit              armed = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      armed        <= 1'b0;
      bus.RDY_Sqrt <= 1'b0;
    end else if (bus.STARTCALC && !bus.BUSY) begin
      cand         <= 0;
      bus.RDY_Sqrt <= 1'b0;
    end else if (bus.RST_Sqrt) begin
      check("invec0_at_clr", bus.invec0, exp_q);
      check("invec1_at_clr", bus.invec1, (cand < MAXV) ? exp_c[cand] : '0);
      check("rst_acc_at_clr", VW'(bus.RST_Acc), VW'(1));
      cur          <= cand;
      cand         <= cand + 1;
      armed        <= (cand != hang_cand);
      lat          <= $urandom_range(0, 3);
      bus.RDY_Sqrt <= 1'b0;
    end else if (armed && bus.EN_Sqrt) begin
      if (lat == 0) begin
        bus.RDY_Sqrt <= 1'b1;
        bus.DIST_In  <= dist_tab[cur];
        armed        <= 1'b0;
      end else begin
        lat <= lat - 1;
      end
    end else begin
      bus.RDY_Sqrt <= 1'b0;
    end
  end

  // One full job: build expectations, start, wait for DONE, compare results.
  task automatic run_job(input int num, input logic [AW-1:0] base, input bit poke);
    int              n_eff;
    logic [VARW-1:0] best;
    int              bidx;
    bit              exp_err;
    int              waited;
    bit              seen;
    int              bad;
    int              exp_len;
    logic [AW:0]     exp_ent;

    n_eff = (num > MAXV) ? MAXV : num;
    for (int e = 0; e < VECW; e++)
      exp_q[e*VARW +: VARW] = mem[(int'(base) + e) % 256];
    for (int k = 0; k < n_eff; k++)
      for (int e = 0; e < VECW; e++)
        exp_c[k][e*VARW +: VARW] = mem[(int'(base) + (k + 1) * VECW + e) % 256];
    best    = '1;
    bidx    = 0;
    exp_err = 1'b0;
    for (int k = 0; k < n_eff; k++) begin
      if (k == hang_cand) exp_err = 1'b1;
      else if (dist_tab[k] < best) begin
        best = dist_tab[k];
        bidx = k;
      end
    end

    addr_log.delete();
    bus.NUM_OF_VECTORS = CW'(num);
    bus.BASE_ADDR      = base;
    bus.STARTCALC      = 1'b1;
    @(posedge clk); #1;
    bus.STARTCALC = 1'b0;
    check("busy_after_start", VW'(bus.BUSY), VW'(1));

    seen   = 1'b0;
    waited = 1;
    if (bus.DONE) seen = 1'b1;
    while (!seen && waited < 3000) begin
      if (poke && bus.EN_Sqrt) begin
        bus.STARTCALC      = 1'b1;
        bus.NUM_OF_VECTORS = CW'(1);
        poke               = 1'b0;
      end
      @(posedge clk); #1;
      bus.STARTCALC = 1'b0;
      waited++;
      if (bus.DONE) seen = 1'b1;
    end
    check("done_seen", VW'(seen), VW'(1));
    if (num == 0) check("zero_done_latency", VW'(waited), VW'(2));
    check("busy_at_done", VW'(bus.BUSY), VW'(0));
    check("best_dist", VW'(bus.BEST_DIST), VW'(best));
    check("best_idx", VW'(bus.BEST_IDX), VW'(bidx));
    check("err", VW'(bus.ERR), VW'(exp_err));
    if (n_eff > 0) check("invec0_final", bus.invec0, exp_q);

    exp_len = (n_eff == 0) ? 0 : (n_eff + 1) * VECW;
    check("addr_count", VW'(addr_log.size()), VW'(exp_len));
    bad = 0;
    for (int i = 0; i < addr_log.size() && i < exp_len; i++) begin
      exp_ent = {(i < VECW) ? 1'b1 : 1'b0, AW'((int'(base) + i) % 256)};
      if (addr_log[i] !== exp_ent) bad++;
    end
    check("addr_sequence", VW'(bad), VW'(0));

    @(posedge clk); #1;
    check("done_single_cycle", VW'(bus.DONE), VW'(0));
    check("best_dist_hold", VW'(bus.BEST_DIST), VW'(best));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_n;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int i = 0; i < 16; i++) mem[i] = VARW'(i + 1);
    for (int i = 0; i < MAXV; i++) dist_tab[i] = '1;

    rst                = 1'b1;
    bus.STARTCALC      = 1'b0;
    bus.NUM_OF_VECTORS = '0;
    bus.BASE_ADDR      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", VW'(bus.BUSY), VW'(0));
    check("rst_flag", VW'(bus.FLAG_Bram), VW'(0));
    check("rst_best_dist", VW'(bus.BEST_DIST), VW'(0));
    check("rst_invec0", bus.invec0, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Nearest neighbour: 50, 20, 30 -> index 1.
    dist_tab[0] = 50; dist_tab[1] = 20; dist_tab[2] = 30;
    run_job(3, 8'd0, 1'b0);
    check("nn_invec0_packed", bus.invec0, {32'd4, 32'd3, 32'd2, 32'd1});

    // Tie keeps the lower index.
    dist_tab[0] = 7; dist_tab[1] = 7;
    run_job(2, 8'd0, 1'b0);

    // Zero count.
    run_job(0, 8'd40, 1'b0);

    // Clamp, ignored restart during CALC, and address wrap.
    for (int i = 0; i < MAXV; i++) dist_tab[i] = VARW'($urandom_range(100, 200));
    dist_tab[13] = 3;
    run_job(MAXV + 4, 8'd250, 1'b1);
    run_job(31, 8'd252, 1'b0);

    // Randomized jobs with small distances so ties occur.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < MAXV; i++) dist_tab[i] = VARW'($urandom_range(0, 15));
      run_job($urandom_range(1, 6), AW'($urandom_range(0, 255)), r[0]);
    end

`ifdef DIST_TIMEOUT_EN
    // Candidate 0 never answers; candidate 1 returns 5.
    hang_cand   = 0;
    dist_tab[0] = 1;
    dist_tab[1] = 5;
    run_job(2, 8'd16, 1'b0);
    hang_cand   = -1;
`endif

    // Reset in the middle of a candidate load.
    bus.NUM_OF_VECTORS = CW'(3);
    bus.BASE_ADDR      = 8'd0;
    bus.STARTCALC      = 1'b1;
    @(posedge clk); #1;
    bus.STARTCALC = 1'b0;
    wait_n = 0;
    while (!(bus.FLAG_Bram[3] && !bus.FLAG_Bram[0]) && wait_n < 200) begin
      @(posedge clk); #1;
      wait_n++;
    end
    check("reached_ldc", VW'(wait_n < 200), VW'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_cs", VW'(bus.FLAG_Bram), VW'(0));
    check("midrst_addr", VW'(bus.ADDR_Bram), VW'(0));
    check("midrst_busy", VW'(bus.BUSY), VW'(0));
    check("midrst_invec0", bus.invec0, '0);
    check("midrst_invec1", bus.invec1, '0);
    check("midrst_best", VW'({bus.BEST_IDX, bus.BEST_DIST}), VW'(0));
    check("midrst_en", VW'({bus.EN_Pipe, bus.EN_Acc, bus.EN_Sqrt, bus.RST_Acc, bus.RST_Sqrt}), VW'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < MAXV; i++) dist_tab[i] = VARW'($urandom_range(0, 99));
    run_job(4, 8'd100, 1'b0);

    check("we_never_set", VW'(we_seen), VW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
